// File: rtl/key_event_arbiter_pkg.sv
// Shared types for the keyboard event arbiter.
// Holds the scan-code map, key/event types and the classification helper.
package kbd_pkg;

  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  localparam logic [7:0] SC_L = 8'h4B;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } key_idx_t;

  typedef struct packed {
    logic     make;
    key_idx_t key;
  } key_evt_t;

  typedef struct packed {
    logic     hit;
    logic     player;
    key_idx_t key;
  } key_class_t;

  function automatic key_class_t classify(input logic [7:0] code);
    key_class_t c;
    c.hit    = 1'b1;
    c.player = 1'b0;
    c.key    = UP;
    case (code)
      SC_W: c.key = UP;
      SC_A: c.key = LEFT;
      SC_S: c.key = DOWN;
      SC_D: c.key = RIGHT;
      SC_I: begin c.player = 1'b1; c.key = UP;    end
      SC_J: begin c.player = 1'b1; c.key = LEFT;  end
      SC_K: begin c.player = 1'b1; c.key = DOWN;  end
      SC_L: begin c.player = 1'b1; c.key = RIGHT; end
      default: c.hit = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/key_event_arbiter_if.sv
// Bundle between the keyboard driver, the arbiter and the two player consumers.
// The slave side is the arbiter; the master side is its environment.
interface key_event_arbiter_if;
  import kbd_pkg::*;

  logic       valid;
  logic       makeBreak;
  logic [7:0] outCode;

  logic       p0_valid;
  logic       p0_ready;
  logic [1:0] p0_key;
  logic       p0_make;

  logic       p1_valid;
  logic       p1_ready;
  logic [1:0] p1_key;
  logic       p1_make;

  logic [3:0] held0;
  logic [3:0] held1;
  logic       overflow;

  modport master (
    output valid, makeBreak, outCode, p0_ready, p1_ready,
    input  p0_valid, p0_key, p0_make, p1_valid, p1_key, p1_make,
    input  held0, held1, overflow
  );

  modport slave (
    input  valid, makeBreak, outCode, p0_ready, p1_ready,
    output p0_valid, p0_key, p0_make, p1_valid, p1_key, p1_make,
    output held0, held1, overflow
  );

endinterface

// File: rtl/key_event_fifo.sv
// Per-player event FIFO with occupancy count; push and pop may share an edge
// in every state, including full.
module key_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  key_evt_t               din,
  output logic                   full,
  input  logic                   pop,
  output key_evt_t               dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  key_evt_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage holds payload only, so it is left out of reset; the head is
  // forced to zero while empty to keep the outputs defined.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// Classifies PS/2 key events per player, filters repeats/spurious breaks,
// queues accepted events per player and tracks held-key masks.
module key_event_arbiter
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  key_event_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic             valid_q;
  logic             strobe;
  key_class_t       cls;
  key_evt_t         evt;
  logic             held_bit;
  logic             accept;
  logic [1:0][3:0]  held;
  logic             overflow;

  logic [1:0]       mine;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       lost;
  logic [1:0]       full;
  logic [1:0]       empty;
  key_evt_t         head  [2];
  logic [PTR_W:0]   count [2];

  // Edge detect: one event per rising edge of valid
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= bus.valid;
  end

  assign strobe   = bus.valid & ~valid_q;
  assign cls      = classify(bus.outCode);
  assign evt.make = bus.makeBreak;
  assign evt.key  = cls.key;
  assign held_bit = held[cls.player][cls.key];

  // A make on a held key is typematic; a break on a released key is spurious.
  assign accept = strobe & cls.hit & (bus.makeBreak ^ held_bit);

  assign pop[0] = ~empty[0] & bus.p0_ready;
  assign pop[1] = ~empty[1] & bus.p1_ready;

  always_comb begin
    mine = '0;
    push = '0;
    lost = '0;
    for (int p = 0; p < 2; p++) begin
      mine[p] = accept & (cls.player == 1'(p));
      push[p] = mine[p] & (~full[p] | pop[p]);
      lost[p] = mine[p] & (count[p] == FULL_CNT) & ~pop[p];
    end
  end

  // Held masks follow every accepted event, even one lost to a full queue
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      held     <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) held[cls.player][cls.key] <= bus.makeBreak;
      if (|lost)  overflow <= 1'b1;
    end
  end

  key_event_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk   (CLOCK_50),
    .rst   (reset),
    .push  (push[0]),
    .din   (evt),
    .full  (full[0]),
    .pop   (pop[0]),
    .dout  (head[0]),
    .empty (empty[0]),
    .count (count[0])
  );

  key_event_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk   (CLOCK_50),
    .rst   (reset),
    .push  (push[1]),
    .din   (evt),
    .full  (full[1]),
    .pop   (pop[1]),
    .dout  (head[1]),
    .empty (empty[1]),
    .count (count[1])
  );

  assign bus.p0_valid = ~empty[0];
  assign bus.p0_key   = head[0].key;
  assign bus.p0_make  = head[0].make;
  assign bus.p1_valid = ~empty[1];
  assign bus.p1_key   = head[1].key;
  assign bus.p1_make  = head[1].make;
  assign bus.held0    = held[0];
  assign bus.held1    = held[1];
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_key_event_arbiter;
  import kbd_pkg::*;

  localparam int DEPTH = 8;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;

  key_event_arbiter_if bus ();

  key_event_arbiter #(.DEPTH(DEPTH)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  // Reference model: code table (index/4 = player, index%4 = key)
  logic [7:0] codes [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h43, 8'h3B, 8'h42, 8'h4B};
  bit   [3:0] m_held [2];
  int         m_occ  [2];
  bit         m_ovf;
  bit         m_prev_v;
  logic [2:0] exp_q0 [$];
  logic [2:0] exp_q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop expected events whenever the DUT completes a handshake
  always @(negedge CLOCK_50) begin
    logic [2:0] e;
    if (mon_en) begin
      if (bus.p0_valid && bus.p0_ready) begin
        check("p0_expected_nonempty", 32'(exp_q0.size() > 0), 1);
        if (exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          check("p0_head", {bus.p0_make, bus.p0_key}, e);
        end
      end
      if (bus.p1_valid && bus.p1_ready) begin
        check("p1_expected_nonempty", 32'(exp_q1.size() > 0), 1);
        if (exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          check("p1_head", {bus.p1_make, bus.p1_key}, e);
        end
      end
    end
  end

  function automatic void model_clear();
    m_held[0] = '0; m_held[1] = '0;
    m_occ[0]  = 0;  m_occ[1]  = 0;
    m_ovf     = 1'b0;
    m_prev_v  = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
  endfunction

  // One clock: check committed state, then drive inputs for the next edge
  task automatic step(input bit v, input bit mb, input logic [7:0] code,
                      input bit r0, input bit r1);
    bit pop0, pop1;
    int idx, p, k;
    @(posedge CLOCK_50);
    #1;
    check("p0_valid", bus.p0_valid, 32'(m_occ[0] > 0));
    check("p1_valid", bus.p1_valid, 32'(m_occ[1] > 0));
    check("held0", bus.held0, m_held[0]);
    check("held1", bus.held1, m_held[1]);
    check("overflow", bus.overflow, m_ovf);
    pop0 = (m_occ[0] > 0) && r0;
    pop1 = (m_occ[1] > 0) && r1;
    if (v && !m_prev_v) begin
      idx = -1;
      for (int i = 0; i < 8; i++) if (codes[i] == code) idx = i;
      if (idx >= 0) begin
        p = idx / 4;
        k = idx % 4;
        if (m_held[p][k] != mb) begin
          m_held[p][k] = mb;
          if (m_occ[p] == DEPTH && !(p == 0 ? pop0 : pop1)) m_ovf = 1'b1;
          else begin
            m_occ[p]++;
            if (p == 0) exp_q0.push_back({mb, 2'(k)});
            else        exp_q1.push_back({mb, 2'(k)});
          end
        end
      end
    end
    if (pop0) m_occ[0]--;
    if (pop1) m_occ[1]--;
    m_prev_v      = v;
    bus.valid     = v;
    bus.makeBreak = mb;
    bus.outCode   = code;
    bus.p0_ready  = r0;
    bus.p1_ready  = r1;
  endtask

  task automatic pulse(input bit mb, input logic [7:0] code, input bit r0, input bit r1);
    step(1'b1, mb, code, r0, r1);
    step(1'b0, mb, code, r0, r1);
  endtask

  task automatic idle(input int n, input bit r0, input bit r1);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, r0, r1);
  endtask

  task automatic do_reset();
    mon_en        = 1'b0;
    reset         = 1'b1;
    bus.valid     = 1'b0;
    bus.makeBreak = 1'b0;
    bus.outCode   = 8'h00;
    bus.p0_ready  = 1'b0;
    bus.p1_ready  = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_clear();
    mon_en = 1'b1;
  endtask

  logic [7:0] seq_code [9] = '{8'h1D, 8'h1D, 8'h1C, 8'h1C, 8'h1B, 8'h1B, 8'h23, 8'h23, 8'h1D};
  bit         seq_mb   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    model_clear();
    do_reset();

    // W make: head visible one cycle after the strobe edge
    step(1'b1, 1'b1, 8'h1D, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h1D, 1'b0, 1'b0);
    check("t1_key", bus.p0_key, 0);
    check("t1_make", bus.p0_make, 1);
    check("t1_held0", bus.held0, 4'b0001);
    check("t1_p1_valid", bus.p1_valid, 0);
    idle(3, 1'b1, 1'b1);

    // Typematic A repeats then a break
    for (int i = 0; i < 3; i++) pulse(1'b1, 8'h1C, 1'b1, 1'b1);
    pulse(1'b0, 8'h1C, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    check("t2_held0_bit1", bus.held0[1], 0);

    // Long valid level is a single event; unmapped code is ignored
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'h43, 1'b1, 1'b0);
    idle(2, 1'b1, 1'b0);
    pulse(1'b1, 8'h29, 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    check("t3_held1", bus.held1, 4'b0001);

    // Full queue with a simultaneous pop and push
    do_reset();
    for (int i = 0; i < 8; i++) pulse(seq_mb[i], seq_code[i], 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h1D, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h1D, 1'b0, 1'b0);
    check("t5_overflow", bus.overflow, 0);
    idle(12, 1'b1, 1'b0);

    // Overflow on the ninth event while player 1 keeps flowing
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pulse(seq_mb[i], seq_code[i], 1'b0, 1'b1);
      pulse(~i[0], 8'h3B, 1'b0, 1'b1);
    end
    idle(1, 1'b0, 1'b1);
    check("t4_overflow", bus.overflow, 1);
    idle(12, 1'b1, 1'b1);

    // Asynchronous reset with events queued
    do_reset();
    pulse(1'b1, 8'h1D, 1'b0, 1'b0);
    pulse(1'b1, 8'h1B, 1'b0, 1'b0);
    pulse(1'b1, 8'h43, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("t6_held0_before", bus.held0, 4'b0101);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("t6_p0_valid", bus.p0_valid, 0);
    check("t6_p1_valid", bus.p1_valid, 0);
    check("t6_p0_key", bus.p0_key, 0);
    check("t6_p0_make", bus.p0_make, 0);
    check("t6_held0", bus.held0, 0);
    check("t6_held1", bus.held1, 0);
    check("t6_overflow", bus.overflow, 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [7:0] code;
      sel  = int'($urandom_range(0, 9));
      code = (sel < 8) ? codes[sel] : ((sel == 8) ? 8'h29 : 8'h00);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), code,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    idle(2 * DEPTH + 4, 1'b1, 1'b1);
    @(negedge CLOCK_50);
    check("end_q0_empty", exp_q0.size(), 0);
    check("end_q1_empty", exp_q1.size(), 0);
    check("end_p0_valid", bus.p0_valid, 0);
    check("end_p1_valid", bus.p1_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Sits between keyboard_press_driver (valid / makeBreak / outCode) and the two player-logic consumers of the game.
- Classifies each PS/2 scan-code event into a player and key index, and suppresses typematic repeats and spurious breaks.
- Buffers accepted events in one FIFO per player and delivers them over a valid/ready handshake.
- Keeps a live held-key bitmask per player for level-sensitive consumers.

Parameters:
- DEPTH, 8, entries per player FIFO (power of 2, ≥2).
- PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- valid  in  1  event-present level from keyboard_press_driver.
- makeBreak  in  1  1 = make (press), 0 = break (release).
- outCode  in  8  scan code of the event.
- p0_valid  out  1  player-0 FIFO head valid.
- p0_ready  in  1  player-0 consumer accepts head.
- p0_key  out  2  key index of head (0 = up, 1 = left, 2 = down, 3 = right).
- p0_make  out  1  make/break of head.
- p1_valid, p1_ready, p1_key, p1_make: same meaning, player 1.
- held0  out  4  player-0 held-key mask, bit = key index.
- held1  out  4  player-1 held-key mask.
- overflow  out  1  sticky: an accepted event was lost to a full FIFO.

Behaviour:
- Reset (async, active-high): FIFOs empty, pX_valid = 0, pX_key = 0, pX_make = 0, held0 = held1 = 0, overflow = 0, valid_q = 0. Reset mid-transfer discards all queued events.
- Event strobe: valid_q registers valid; strobe = valid & ~valid_q. One event per rising edge of valid; a valid held high for many cycles is a single event.
- Classification map (combinational on outCode):
  - Player 0: W 0x1D → 0, A 0x1C → 1, S 0x1B → 2, D 0x23 → 3.
  - Player 1: I 0x43 → 0, J 0x3B → 1, K 0x42 → 2, L 0x4B → 3.
  - Any other code: dropped, no state change.
- Filter, for a mapped event on player p, key k:
  - make with heldp[k] = 1: dropped (typematic repeat).
  - break with heldp[k] = 0: dropped (spurious).
  - Otherwise the event is accepted.
- Accepted event: written into FIFO p at the strobe edge, and heldp[k] updated at the same edge (make sets, break clears).
- Full FIFO:
  - If FIFO p is full and no pop occurs that edge, the event is lost: overflow ← 1, heldp still updated so the mask tracks the physical keyboard.
  - overflow clears only on reset.
- Push and pop on the same edge: allowed in every state, including full (occupancy unchanged, no overflow).
- Latency: strobe at edge N → pX_valid = 1 and head fields stable after edge N when the FIFO was empty (1 cycle from valid rising).
- Handshake:
  - Pop on the edge where pX_valid & pX_ready.
  - pX_key and pX_make hold stable while pX_valid & ~pX_ready.
  - pX_ready while empty has no effect.
- Players are independent: a stall on p0 never blocks p1.
- Pointers: PTR_W bits, wrap modulo DEPTH. Occupancy counter is PTR_W+1 bits, 0..DEPTH; full = (count == DEPTH), empty = (count == 0).

Decomposition:
- Package kbd_pkg holds:
  - Scan-code localparams (SC_W, SC_A, SC_S, SC_D, SC_I, SC_J, SC_K, SC_L).
  - key_idx_t (2-bit enum UP/LEFT/DOWN/RIGHT).
  - key_evt_t packed struct {make, key_idx_t key}.
- Sub-module key_event_fifo (parameter DEPTH, payload key_evt_t, push/full/pop/empty/count) is instantiated twice.
- The top holds the edge detect, classification, filter, held masks and overflow.

Test Plan:
1. Reset, then valid pulse with outCode = 0x1D, makeBreak = 1 → next cycle p0_valid = 1, p0_key = 0, p0_make = 1, held0 = 4'b0001; p1_valid stays 0.
2. A make 0x1C three times, then a break → exactly two p0 events (make key 1, break key 1); held0[1] ends at 0.
3. Valid held high for 20 cycles with 0x43 make → single p1 event; outCode 0x29 (space) → no event, masks unchanged.
4. p0_ready = 0, nine distinct accepted p0 events with DEPTH = 8 → 8 queued, overflow = 1; then ready = 1 drains 8 events in order; p1 path unaffected throughout.
5. FIFO full and p0_ready = 1 on the same edge as a new strobe → count stays 8, overflow stays 0.
6. Assert reset with 3 events queued and held0 = 4'b0101 → all outputs 0 immediately, without a clock edge.
